// File: rtl/info_demapper.sv
// Serial information de-mapper: recovers one information bit per clock from a
// captured mapped word using the mapper's mask and position-select fields.
module info_demapper #(
  parameter  int MAPPER_PARALLELISM = 8,
  localparam int P  = MAPPER_PARALLELISM,
  localparam int W  = $clog2(P),
  localparam int CW = $clog2(P + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P-1:0]         d,
  input  logic [P-1:0]         m,
  input  logic [(P-1)*W-1:0]   c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P-1:0]         out_bits,
  output logic [CW-1:0]        info_cnt,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] K_LAST = W'(P - 1);
  localparam logic [W:0]   P_LIM  = (W + 1)'(P);

  state_t             state_q, state_d;
  logic [W-1:0]       k_q;
  logic [P-1:0]       d_q;
  logic [P-1:0]       m_q;
  logic [(P-1)*W-1:0] c_q;

  logic               accept;
  logic [W-1:0]       src_tbl [P];
  logic [W-1:0]       sel;
  logic               src_ok;

  assign accept = in_valid && (state_q == IDLE);

  // NOTE: combinational blocks assign every output a default first so that no
  // path through the case statement can leave a signal unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Position 0 always reads source 0; position k>0 reads select field k-1.
  always_comb begin
    src_tbl[0] = '0;
    for (int j = 0; j < P - 1; j++) src_tbl[j+1] = c_q[j*W +: W];
  end

  assign sel    = src_tbl[k_q];
  assign src_ok = {1'b0, sel} < P_LIM;

  // NOTE: the captured operands are plain data registers with no reset; they
  // are only ever consumed after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      d_q <= d;
      m_q <= m;
      c_q <= c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      out_bits <= '0;
      info_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      k_q      <= '0;
      out_bits <= '0;
      info_cnt <= '0;
      err      <= 1'b0;
    end else if (state_q == RUN) begin
      if (m_q[k_q]) begin
        info_cnt <= info_cnt + CW'(1);
        if (src_ok) begin
          out_bits[k_q] <= d_q[sel];
        end else begin
          out_bits[k_q] <= 1'b0;
          err           <= 1'b1;
        end
      end
      if (k_q != K_LAST) k_q <= k_q + W'(1);
    end
  end

endmodule

// File: tb/tb_info_demapper.sv
// Directed bench for info_demapper: vector table on an 8-wide instance plus
// hand sequences for backpressure, back-to-back, reset and a 6-wide instance.
module tb_info_demapper;

  localparam logic [20:0] C_GOLD = 21'b001010011100101110111;
  localparam logic [14:0] C6     = {3'd4, 3'd3, 3'd2, 3'd1, 3'd7};

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0]  d, m, out_bits;
  logic [20:0] c;
  logic [3:0]  info_cnt;

  logic        in_valid6, in_ready6, out_valid6, out_ready6, err6;
  logic [5:0]  d6, m6, out_bits6;
  logic [14:0] c6;
  logic [2:0]  info_cnt6;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  info_demapper #(.MAPPER_PARALLELISM(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .m(m), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .info_cnt(info_cnt), .err(err)
  );

  info_demapper #(.MAPPER_PARALLELISM(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
    .d(d6), .m(m6), .c(c6), .out_valid(out_valid6), .out_ready(out_ready6),
    .out_bits(out_bits6), .info_cnt(info_cnt6), .err(err6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [7:0]  d;
    logic [7:0]  m;
    logic [20:0] c;
    logic [7:0]  exp_bits;
    logic [3:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready timeout", in_ready, 1);
  endtask

  // Offer one word to the 8-wide instance, then scramble the inputs after the
  // accept edge; returns the cycle count to out_valid.
  task automatic run8(input logic [7:0] dv, input logic [7:0] mv,
                      input logic [20:0] cv, output int lat);
    wait_in_ready();
    in_valid = 1'b1;
    d = dv;
    m = mv;
    c = cv;
    tick();
    in_valid = 1'b0;
    d = ~dv;
    m = ~mv;
    c = ~cv;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run6(input logic [5:0] dv, input logic [5:0] mv, output int lat);
    int n = 0;
    while (!in_ready6 && n < 50) begin
      tick();
      n++;
    end
    in_valid6 = 1'b1;
    d6 = dv;
    m6 = mv;
    c6 = C6;
    tick();
    in_valid6 = 1'b0;
    d6 = ~dv;
    m6 = ~mv;
    c6 = ~C6;
    lat = 0;
    while (!out_valid6 && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int t0;
    int t1;
    int n;
    logic seen;

    vecs[0] = '{"golden",      8'b10101111, 8'b10101111, C_GOLD, 8'b10101011, 4'd6, 1'b0};
    vecs[1] = '{"frozen",      8'hFF,       8'h00,       C_GOLD, 8'h00,       4'd0, 1'b0};
    vecs[2] = '{"zero_data",   8'h00,       8'b10101111, C_GOLD, 8'h00,       4'd6, 1'b0};
    vecs[3] = '{"all_ones",    8'hFF,       8'hFF,       C_GOLD, 8'hFF,       4'd8, 1'b0};
    vecs[4] = '{"dup_src0",    8'h01,       8'hFF,       21'd0,  8'hFF,       4'd8, 1'b0};
    vecs[5] = '{"msb_low_m",   8'h80,       8'h0F,       C_GOLD, 8'h02,       4'd4, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;  out_ready = 1'b1;  d = '0;  m = '0;  c = '0;
    in_valid6 = 1'b0; out_ready6 = 1'b1; d6 = '0; m6 = '0; c6 = '0;
    tick();
    tick();
    check("rst in_ready",  in_ready,  1);
    check("rst out_valid", out_valid, 0);
    check("rst out_bits",  out_bits,  0);
    check("rst info_cnt",  info_cnt,  0);
    check("rst err",       err,       0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].d, vecs[i].m, vecs[i].c, lat);
      check({vecs[i].name, " latency"},  lat,       8);
      check({vecs[i].name, " out_bits"}, out_bits,  vecs[i].exp_bits);
      check({vecs[i].name, " info_cnt"}, info_cnt,  vecs[i].exp_cnt);
      check({vecs[i].name, " err"},      err,       vecs[i].exp_err);
      check({vecs[i].name, " in_ready"}, in_ready,  0);
    end
    tick();
    check("release to idle", in_ready, 1);

    // Backpressure: hold the result for 5 cycles while a new word is offered.
    out_ready = 1'b0;
    run8(8'b10101111, 8'b10101111, C_GOLD, lat);
    check("bp latency", lat, 8);
    in_valid = 1'b1;
    d = 8'h00;
    m = 8'b10101111;
    c = C_GOLD;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", out_valid, 1);
      check("bp in_ready",  in_ready,  0);
      check("bp out_bits",  out_bits,  8'b10101011);
      check("bp info_cnt",  info_cnt,  6);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp released out_valid", out_valid, 0);
    check("bp released in_ready",  in_ready,  1);
    check("bp result persists",    out_bits,  8'b10101011);

    // Back-to-back: in_valid held high, second word accepted P+2 cycles later.
    in_valid = 1'b1;
    d = 8'b10101111;
    m = 8'b10101111;
    c = C_GOLD;
    wait_in_ready();
    @(posedge clk);
    t0 = cyc;
    #1;
    d = 8'h00;
    n = 0;
    seen = 1'b0;
    while (!in_ready && n < 50) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        check("b2b first out_bits", out_bits, 8'b10101011);
        check("b2b in_valid overlap", in_ready & out_valid, 0);
      end
      tick();
      n++;
    end
    check("b2b first seen", seen, 1);
    @(posedge clk);
    t1 = cyc;
    #1;
    in_valid = 1'b0;
    check("b2b accept spacing", t1 - t0, 10);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("b2b second out_bits", out_bits, 8'h00);
    check("b2b second info_cnt", info_cnt, 6);
    tick();

    // Reset asserted during the fourth RUN cycle.
    wait_in_ready();
    in_valid = 1'b1;
    d = 8'b10101111;
    m = 8'b10101111;
    c = C_GOLD;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("pre-reset partial bits", out_bits, 8'b00000011);
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst in_ready",  in_ready,  1);
    check("mid rst out_bits",  out_bits,  0);
    check("mid rst info_cnt",  info_cnt,  0);
    tick();
    rst_n = 1'b1;
    tick();
    run8(8'b10101111, 8'b10101111, C_GOLD, lat);
    check("post rst latency",  lat,      8);
    check("post rst out_bits", out_bits, 8'b10101011);
    check("post rst info_cnt", info_cnt, 6);
    check("post rst err",      err,      0);
    tick();

    // 6-wide instance: select field 0 is out of range.
    run6(6'b111111, 6'b000011, lat);
    check("p6 latency",  lat,       6);
    check("p6 out_bits", out_bits6, 6'b000001);
    check("p6 info_cnt", info_cnt6, 2);
    check("p6 err",      err6,      1);
    tick();
    run6(6'b111111, 6'b000001, lat);
    check("p6 masked out_bits", out_bits6, 6'b000001);
    check("p6 masked info_cnt", info_cnt6, 1);
    check("p6 masked err",      err6,      0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/info_demapper.md
# info_demapper

Serial inverse of the information mapper. It accepts one mapped word together with the same mask `m` and position-select vector `c` that the mapper used. It recovers the information bits one position per clock and returns the de-mapped word with a count of information bits. It sits on the receive side, between the word source and the information-bit consumer, and uses a valid/ready handshake on both sides.

## Interface
- `MAPPER_PARALLELISM`, default 8: word width P, at least 2.
- Derived W = $clog2(P): width of one select field.
- Derived CW = $clog2(P+1): width of the count.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: input word offered.
- `in_ready` output 1: demapper can accept a word; high only in IDLE.
- `d` input P: mapped word.
- `m` input P: mask; 1 marks an information position.
- `c` input (P-1)*W: select fields; field j = `c[j*W +: W]` for j = 0..P-2.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_bits` output P: de-mapped word.
- `info_cnt` output CW: number of information bits, popcount(m).
- `err` output 1: an out-of-range select field was used.

## Operation
- States: IDLE, RUN, DONE. Position counter k is W bits wide (W+1 bits if P is a power of two is not required; k stops at P-1).
- **IDLE** (`in_ready`=1). On `in_valid`&&`in_ready`:
  - capture `d`, `m` and `c`;
  - clear `out_bits`, `info_cnt` and `err`;
  - set k=0 and go to RUN.
- **RUN**, one position per clock:
  - Source index: s = 0 when k=0, otherwise s = field k-1.
  - If m[k]=1 and s<P: `out_bits[k]` <= captured d[s], and `info_cnt` increments.
  - If m[k]=1 and s≥P: `out_bits[k]` <= 0, `err` <= 1 (sticky for this word), and `info_cnt` still increments.
  - If m[k]=0: `out_bits[k]` stays 0, and the field is ignored even if out of range.
  - When k=P-1 is processed, go to DONE. Otherwise k increments.
- **DONE** (`out_valid`=1). Outputs are held stable until `out_valid`&&`out_ready`, then go to IDLE. Results persist in IDLE until the next accept clears them.
- Inputs are sampled only at the accept edge. Changes to `d`, `m` or `c` afterwards have no effect.
- Duplicate select values are legal. Each output position reads its own source independently.
- Reset, asynchronous and any time including mid-RUN or DONE: state=IDLE, k=0, `in_ready`=1, `out_valid`=0, `out_bits`=0, `info_cnt`=0, `err`=0. A partially processed word is discarded.

## Timing
- Accept at edge E0. RUN processes positions at edges E1..EP. `out_valid` rises after EP, so latency is P cycles from accept to `out_valid`.
- `in_ready` is low from after E0 until the edge that completes the output handshake.
- With `out_ready` held high, DONE lasts one cycle, then one IDLE cycle follows. Minimum word period is P+2 cycles.
- `in_ready` and `out_valid` are never high together.
- No combinational path from any input to any output. All outputs are registered or decoded from state.

## Test plan
- **Golden case.** P=8, `d`=8'b10101111, `m`=8'b10101111, `c`=21'b001010011100101110111 (fields 7,6,5,4,3,2,1), `out_ready`=1.
  - Required: `out_valid` 8 cycles after accept, `out_bits`=8'b10101011, `info_cnt`=6, `err`=0.
- **All positions frozen.** P=8, `d`=8'hFF, `m`=8'h00, same `c`.
  - Required: `out_bits`=0, `info_cnt`=0, `err`=0.
- **Backpressure.** Golden case with `out_ready` low for 5 cycles after `out_valid` rises.
  - Required: outputs stable and `in_ready`=0 throughout. A new `in_valid` during this time is not accepted. The result is released on the first edge with `out_ready`=1.
- **Back-to-back words.** Golden case, then `d`=8'h00 with the same `m` and `c`, `in_valid` held high and `out_ready`=1.
  - Required: second accept exactly P+2 cycles after the first; second `out_bits`=0, `info_cnt`=6.
- **Reset mid-operation.** Assert `rst_n`=0 at the fourth RUN cycle of the golden case.
  - Required: immediately `out_valid`=0, `in_ready`=1, `out_bits`=0. After release, a fresh golden word gives the golden result.
- **Out-of-range select.** P=6 (W=3), `d`=6'b111111, `m`=6'b000011, fields {7,1,2,3,4}.
  - Required: `out_bits`=6'b000001, `info_cnt`=2, `err`=1.
  - Repeat with `m`=6'b000001. Required: `err`=0.
